// File: rtl/sme_multi.sv
// Streaming string-matching engine: stores a string, then scans each later
// pattern against it with '^', '$' and '.' wildcards and optional case folding.
module sme_multi #(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int CHAR_W    = 8,
  parameter int IDX_W     = $clog2(STR_DEPTH),
  parameter int CNT_W     = $clog2(STR_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] chardata,
  input  logic              isstring,
  input  logic              ispattern,
  input  logic              nocase,
  output logic              busy,
  output logic              valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_index,
  output logic [CNT_W-1:0]  match_count
);

  localparam int PCNT_W = $clog2(PAT_DEPTH + 1);
  localparam int POS_W  = $clog2(STR_DEPTH + PAT_DEPTH + 1);

  localparam logic [CHAR_W-1:0] C_CARET  = CHAR_W'('h5E);
  localparam logic [CHAR_W-1:0] C_DOLLAR = CHAR_W'('h24);
  localparam logic [CHAR_W-1:0] C_DOT    = CHAR_W'('h2E);
  localparam logic [CHAR_W-1:0] C_SPACE  = CHAR_W'('h20);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_STR,
    S_LOAD_PAT,
    S_MATCH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CHAR_W-1:0]  r_str [STR_DEPTH];
  logic [CHAR_W-1:0]  r_pat [PAT_DEPTH];
  logic [CNT_W-1:0]   r_str_len;
  logic [PCNT_W-1:0]  r_pat_len;
  logic               r_nocase;
  logic [IDX_W-1:0]   r_pos;
  logic               r_valid;
  logic               r_match;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_anc_s;
  logic               w_anc_e;
  logic [CHAR_W-1:0]  w_last_pch;
  logic [PCNT_W-1:0]  w_core_len;
  logic [CHAR_W-1:0]  w_core [PAT_DEPTH];
  logic [CHAR_W-1:0]  w_win  [PAT_DEPTH+1];
  logic [CHAR_W-1:0]  w_prev;
  logic [CHAR_W-1:0]  w_end_ch;
  logic [POS_W-1:0]   w_s;
  logic [POS_W-1:0]   w_s_end;
  logic               w_len_ok;
  logic               w_core_ok;
  logic               w_hit;
  logic               w_last;

  function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c,
                                             input logic en);
    if (en && c >= CHAR_W'('h41) && c <= CHAR_W'('h5A))
      return c | CHAR_W'('h20);
    return c;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (isstring)       w_state_nxt = S_LOAD_STR;
        else if (ispattern) w_state_nxt = S_LOAD_PAT;
      end
      S_LOAD_STR: if (!isstring) w_state_nxt = S_IDLE;
      S_LOAD_PAT: begin
        // An empty string has no candidates, so the result is issued directly
        if (!ispattern) w_state_nxt = (r_str_len == '0) ? S_IDLE : S_MATCH;
      end
      S_MATCH: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < STR_DEPTH; j++) begin
      if (isstring && ((r_state == S_IDLE && j == 0) ||
                       (r_state == S_LOAD_STR && CNT_W'(j) == r_str_len)))
        r_str[j] <= chardata;
    end
    for (int unsigned j = 0; j < PAT_DEPTH; j++) begin
      if (ispattern && !isstring &&
          ((r_state == S_IDLE && j == 0) ||
           (r_state == S_LOAD_PAT && PCNT_W'(j) == r_pat_len)))
        r_pat[j] <= chardata;
    end
  end

  always_comb begin
    w_anc_s    = (r_pat_len != '0) && (r_pat[0] == C_CARET);
    w_last_pch = '0;
    for (int unsigned k = 0; k < PAT_DEPTH; k++) begin
      if (PCNT_W'(k) + PCNT_W'(1) == r_pat_len) w_last_pch = r_pat[k];
    end
    w_anc_e    = (r_pat_len > PCNT_W'(w_anc_s)) && (w_last_pch == C_DOLLAR);
    w_core_len = r_pat_len - PCNT_W'(w_anc_s) - PCNT_W'(w_anc_e);

    for (int unsigned k = 0; k < PAT_DEPTH; k++) begin
      w_core[k] = '0;
      for (int unsigned j = 0; j < PAT_DEPTH; j++) begin
        if (j == k + (w_anc_s ? 1 : 0)) w_core[k] = r_pat[j];
      end
    end

    // Window of string characters starting at the current candidate; one
    // extra slot supplies the character that follows the core for '$'
    w_s = POS_W'(r_pos);
    for (int unsigned k = 0; k <= PAT_DEPTH; k++) begin
      w_win[k] = '0;
      for (int unsigned j = 0; j < STR_DEPTH; j++) begin
        if (POS_W'(j) == w_s + POS_W'(k)) w_win[k] = r_str[j];
      end
    end

    w_prev = C_SPACE;
    for (int unsigned j = 0; j < STR_DEPTH; j++) begin
      if (r_pos != '0 && POS_W'(j) + POS_W'(1) == w_s) w_prev = r_str[j];
    end

    w_end_ch = '0;
    for (int unsigned k = 0; k <= PAT_DEPTH; k++) begin
      if (PCNT_W'(k) == w_core_len) w_end_ch = w_win[k];
    end

    w_s_end   = w_s + POS_W'(w_core_len);
    w_len_ok  = w_s_end <= POS_W'(r_str_len);
    w_core_ok = 1'b1;
    for (int unsigned k = 0; k < PAT_DEPTH; k++) begin
      if (PCNT_W'(k) < w_core_len && w_core[k] != C_DOT &&
          fold(w_core[k], r_nocase) != fold(w_win[k], r_nocase))
        w_core_ok = 1'b0;
    end

    w_hit  = (w_core_len != '0) && w_len_ok && w_core_ok &&
             (!w_anc_s || w_prev == C_SPACE) &&
             (!w_anc_e || w_s_end == POS_W'(r_str_len) || w_end_ch == C_SPACE);
    w_last = (CNT_W'(r_pos) + CNT_W'(1)) == r_str_len;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_str_len <= '0;
      r_pat_len <= '0;
      r_nocase  <= 1'b0;
      r_pos     <= '0;
      r_valid   <= 1'b0;
      r_match   <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (isstring) begin
            r_str_len <= CNT_W'(1);
          end else if (ispattern) begin
            r_pat_len <= PCNT_W'(1);
            r_nocase  <= nocase;
            r_match   <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
          end
        end
        S_LOAD_STR: begin
          if (isstring && r_str_len < CNT_W'(STR_DEPTH))
            r_str_len <= r_str_len + CNT_W'(1);
        end
        S_LOAD_PAT: begin
          if (ispattern) begin
            if (!isstring && r_pat_len < PCNT_W'(PAT_DEPTH))
              r_pat_len <= r_pat_len + PCNT_W'(1);
          end else begin
            r_pos <= '0;
            if (r_str_len == '0) r_valid <= 1'b1;
          end
        end
        S_MATCH: begin
          if (w_hit) begin
            if (r_cnt != CNT_W'(STR_DEPTH)) r_cnt <= r_cnt + CNT_W'(1);
            if (!r_match) begin
              r_match <= 1'b1;
              r_idx   <= r_pos;
            end
          end
          if (w_last) r_valid <= 1'b1;
          else        r_pos   <= r_pos + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_LOAD_PAT) || (r_state == S_MATCH);
  assign valid       = r_valid;
  assign match       = r_match;
  assign match_index = r_idx;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_sme_multi.sv
// Scoreboard bench for sme_multi: expected results and arrival cycles are queued
// as each pattern is driven and checked when valid strobes.
module tb_sme_multi;

  localparam int STR_DEPTH = 32;
  localparam int PAT_DEPTH = 8;
  localparam int CHAR_W    = 8;
  localparam int IDX_W     = 5;
  localparam int CNT_W     = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [CHAR_W-1:0] chardata = '0;
  logic              isstring = 1'b0;
  logic              ispattern = 1'b0;
  logic              nocase = 1'b0;
  logic              busy;
  logic              valid;
  logic              match;
  logic [IDX_W-1:0]  match_index;
  logic [CNT_W-1:0]  match_count;

  sme_multi #(
    .STR_DEPTH(STR_DEPTH),
    .PAT_DEPTH(PAT_DEPTH),
    .CHAR_W   (CHAR_W),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chardata   (chardata),
    .isstring   (isstring),
    .ispattern  (ispattern),
    .nocase     (nocase),
    .busy       (busy),
    .valid      (valid),
    .match      (match),
    .match_index(match_index),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int unsigned m;
    int unsigned idx;
    int unsigned cnt;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input int unsigned got,
                          input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq({e.tag, ".match"}, 32'(match), e.m);
        check_eq({e.tag, ".index"}, 32'(match_index), e.idx);
        check_eq({e.tag, ".count"}, 32'(match_count), e.cnt);
        check_eq({e.tag, ".cycle"}, cyc, e.at);
        check_eq({e.tag, ".busy_low"}, 32'(busy), 0);
      end
    end
  end

  task automatic drive(input logic s, input logic p, input logic n,
                       input logic [7:0] c);
    @(posedge clk);
    #1;
    isstring  = s;
    ispattern = p;
    nocase    = n;
    chardata  = c;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, 1'b0, 1'b0, s[i]);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // len is the stored string length the result is expected against
  task automatic run_pat(input string tag, input string p, input logic nc,
                         input int unsigned em, input int unsigned ei,
                         input int unsigned ec, input int unsigned len);
    exp_t e;
    for (int i = 0; i < p.len(); i++) begin
      drive(1'b0, 1'b1, nc, p[i]);
      if (i == 1) check_eq({tag, ".busy_high"}, 32'(busy), 1);
      if (i == p.len() - 1) begin
        e.tag = tag; e.m = em; e.idx = ei; e.cnt = ec;
        e.at  = cyc + 1 + len + 1;
        sb.push_back(e);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    if (p.len() == 1) check_eq({tag, ".busy_high"}, 32'(busy), 1);
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check_eq({tag, ".timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    string s;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.valid", 32'(valid), 0);
    check_eq("rst.match", 32'(match), 0);
    check_eq("rst.index", 32'(match_index), 0);
    check_eq("rst.count", 32'(match_count), 0);
    check_eq("rst.busy",  32'(busy), 0);
    reset = 1'b1;

    load_str("hello world");
    run_pat("wor",   "wor",  1'b0, 1, 6, 1, 11);
    run_pat("^w.r",  "^w.r", 1'b0, 1, 6, 1, 11);
    run_pat("lo$",   "lo$",  1'b0, 1, 3, 1, 11);
    run_pat("o",     "o",    1'b0, 1, 4, 2, 11);
    run_pat("^orl",  "^orl", 1'b0, 0, 0, 0, 11);

    load_str("Hello");
    run_pat("hEL_nc", "hEL", 1'b1, 1, 0, 1, 5);
    run_pat("hEL_cs", "hEL", 1'b0, 0, 0, 0, 5);
    run_pat("dotend", ".$",  1'b0, 1, 4, 1, 5);

    s = "";
    for (int i = 0; i < 32; i++) s = {s, "a"};
    s = {s, "b"};
    load_str(s);
    run_pat("a8",    "aaaaaaaa",  1'b0, 1, 0, 25, 32);
    run_pat("a_end", "a$",        1'b0, 1, 31, 1, 32);
    run_pat("a9",    "aaaaaaaab", 1'b0, 1, 0, 25, 32);

    drive(1'b1, 1'b1, 1'b0, "x");
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    run_pat("both_x",  "x",   1'b0, 1, 0, 1, 1);
    run_pat("both_ax", "^x$", 1'b0, 1, 0, 1, 1);
    run_pat("caret",   "^",   1'b0, 0, 0, 0, 1);
    run_pat("dollar",  "$",   1'b0, 0, 0, 0, 1);
    run_pat("cd",      "^$",  1'b0, 0, 0, 0, 1);

    load_str("hello world");
    drive(1'b0, 1'b1, 1'b0, "w");
    drive(1'b0, 1'b1, 1'b0, "o");
    drive(1'b0, 1'b1, 1'b0, "r");
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (9) drive(1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("mid.busy",  32'(busy), 1);
    check_eq("mid.match", 32'(match), 1);
    reset = 1'b0;
    #1;
    check_eq("abort.valid", 32'(valid), 0);
    check_eq("abort.match", 32'(match), 0);
    check_eq("abort.index", 32'(match_index), 0);
    check_eq("abort.count", 32'(match_count), 0);
    check_eq("abort.busy",  32'(busy), 0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    run_pat("empty", "o", 1'b0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
